mc_ctrl_fsm: RTL and testbench

- Multi-cycle main control unit for the MIPS-subset CPU datapath.
- Decodes the instruction-register opcode and sequences fetch, decode, execute, memory and write-back over several cycles.
- Drives all datapath select and enable lines, including the write-register destination select (RegDst) and the register-file write enable.
- Stalls on a memory-ready handshake and flags unsupported opcodes.

---
 rtl/mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multi-cycle main control unit for the MIPS-subset datapath.
//               Sequences fetch/decode/execute/memory/write-back, drives all
//               datapath selects and enables, stalls on mem_ready and flags
//               unsupported opcodes with a registered one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_FETCH    = 4'd1;
    localparam logic [3:0] c_DECODE   = 4'd2;
    localparam logic [3:0] c_MEMADR   = 4'd3;
    localparam logic [3:0] c_MEMRD    = 4'd4;
    localparam logic [3:0] c_MEMWB    = 4'd5;
    localparam logic [3:0] c_MEMWR    = 4'd6;
    localparam logic [3:0] c_EXEC     = 4'd7;
    localparam logic [3:0] c_RTYPE_WB = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JUMP     = 4'd10;
    localparam logic [3:0] c_ADDI_EX  = 4'd11;
    localparam logic [3:0] c_ADDI_WB  = 4'd12;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;
    logic       w_illegal;

    // Next-state selection; opcode only matters in DECODE and MEMADR.
    always_comb begin
        w_next    = c_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            c_IDLE:   w_next = c_FETCH;
            c_FETCH:  w_next = mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = c_MEMADR;
                    OP_RTYPE:     w_next = c_EXEC;
                    OP_BEQ:       w_next = c_BRANCH;
                    OP_J:         w_next = c_JUMP;
                    OP_ADDI:      w_next = c_ADDI_EX;
                    default: begin
                        w_next    = c_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                // A non-memory opcode here means IR changed under us; recover to FETCH.
                if (opcode == OP_LW)
                    w_next = c_MEMRD;
                else if (opcode == OP_SW)
                    w_next = c_MEMWR;
                else
                    w_next = c_FETCH;
            end
            c_MEMRD:    w_next = mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWB:    w_next = c_FETCH;
            c_MEMWR:    w_next = mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC:     w_next = c_RTYPE_WB;
            c_RTYPE_WB: w_next = c_FETCH;
            c_BRANCH:   w_next = c_FETCH;
            c_JUMP:     w_next = c_FETCH;
            c_ADDI_EX:  w_next = c_ADDI_WB;
            c_ADDI_WB:  w_next = c_FETCH;
            default:    w_next = c_FETCH;
        endcase
    end

    // State and illegal-opcode pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
        end
    end

    // Moore output decode; only FETCH gates IRWrite/PCWrite with mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (r_state)
            c_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            c_DECODE: begin
                ALUSrcB = 2'b11;
            end
            c_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            c_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            c_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            c_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            c_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            c_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            c_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_op = r_illegal;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Self-checking bench for mc_ctrl_fsm: directed vector table,
//               hand-written multi-cycle sequences, and randomized
//               instruction streams against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [5:0] c_RT = 6'b000000;
    localparam logic [5:0] c_LW = 6'b100011;
    localparam logic [5:0] c_SW = 6'b101011;
    localparam logic [5:0] c_BQ = 6'b000100;
    localparam logic [5:0] c_JP = 6'b000010;
    localparam logic [5:0] c_AI = 6'b001000;
    localparam logic [5:0] c_XX = 6'b111111;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MADR = 4'd3,
                           S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_EXEC = 4'd7,
                           S_RWB = 4'd8, S_BR = 4'd9, S_JMP = 4'd10, S_AEX = 4'd11,
                           S_AWB = 4'd12;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    ctl_t       w_act;

    int nvec = 0;
    int nerr = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign w_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, illegal_op};

    // Expected control word for a state, taken from the per-state output table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic mr, input logic ill);
        ctl_t c;
        c = '0;
        c.ill = ill;
        case (st)
            S_FETCH: begin c.mrd = 1'b1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
            S_DEC:   c.asb = 2'b11;
            S_MADR:  begin c.asa = 1'b1; c.asb = 2'b10; end
            S_MRD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
            S_MWB:   begin c.rw = 1'b1; c.m2r = 1'b1; end
            S_MWR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
            S_EXEC:  begin c.asa = 1'b1; c.aop = 2'b10; end
            S_RWB:   begin c.rw = 1'b1; c.rdst = 1'b1; end
            S_BR:    begin c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.psrc = 2'b01; end
            S_JMP:   begin c.pcw = 1'b1; c.psrc = 2'b10; end
            S_AEX:   begin c.asa = 1'b1; c.asb = 2'b10; end
            S_AWB:   c.rw = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == c_RT) || (op == c_LW) || (op == c_SW) ||
               (op == c_BQ) || (op == c_JP) || (op == c_AI);
    endfunction

    // One clock: drive inputs just after the edge, check mid-cycle.
    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input logic [3:0] est, input logic eill, input string nm);
        ctl_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        opcode    = op;
        mem_ready = mr;
        #3;
        e = exp_ctl(est, mr, eill);
        nvec++;
        if (state !== est || w_act !== e) begin
            nerr++;
            $display("FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                     nm, state, w_act, est, e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    vec_t tbl[23];
    cyc_t q[$];

    function automatic logic [5:0] rop();
        return 6'($urandom_range(63, 0));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Instruction-level model: expands one instruction into its cycle stream.
    task automatic push_instr(input logic [5:0] op, input int sf, input int sm);
        repeat (sf) q.push_back('{rop(), 1'b0, S_FETCH});
        q.push_back('{rop(), 1'b1, S_FETCH});
        q.push_back('{op, rbit(), S_DEC});
        case (op)
            c_LW: begin
                q.push_back('{op, rbit(), S_MADR});
                repeat (sm) q.push_back('{rop(), 1'b0, S_MRD});
                q.push_back('{rop(), 1'b1, S_MRD});
                q.push_back('{rop(), rbit(), S_MWB});
            end
            c_SW: begin
                q.push_back('{op, rbit(), S_MADR});
                repeat (sm) q.push_back('{rop(), 1'b0, S_MWR});
                q.push_back('{rop(), 1'b1, S_MWR});
            end
            c_RT: begin
                q.push_back('{rop(), rbit(), S_EXEC});
                q.push_back('{rop(), rbit(), S_RWB});
            end
            c_BQ: q.push_back('{rop(), rbit(), S_BR});
            c_JP: q.push_back('{rop(), rbit(), S_JMP});
            c_AI: begin
                q.push_back('{rop(), rbit(), S_AEX});
                q.push_back('{rop(), rbit(), S_AWB});
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] op;
        logic       prev_ill;
        int         len;

        // Directed table: R-type with stalls, BEQ, J, illegal, reset after illegal, ADDI.
        tbl[0]  = '{1'b1, c_RT, 1'b1, S_IDLE,  1'b0};
        tbl[1]  = '{1'b1, c_XX, 1'b1, S_FETCH, 1'b0};
        tbl[2]  = '{1'b1, c_RT, 1'b1, S_DEC,   1'b0};
        tbl[3]  = '{1'b1, c_XX, 1'b0, S_EXEC,  1'b0};
        tbl[4]  = '{1'b1, c_RT, 1'b0, S_RWB,   1'b0};
        tbl[5]  = '{1'b1, c_RT, 1'b0, S_FETCH, 1'b0};
        tbl[6]  = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b0};
        tbl[7]  = '{1'b1, c_BQ, 1'b1, S_DEC,   1'b0};
        tbl[8]  = '{1'b1, c_RT, 1'b1, S_BR,    1'b0};
        tbl[9]  = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b0};
        tbl[10] = '{1'b1, c_JP, 1'b1, S_DEC,   1'b0};
        tbl[11] = '{1'b1, c_RT, 1'b1, S_JMP,   1'b0};
        tbl[12] = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b0};
        tbl[13] = '{1'b1, c_XX, 1'b1, S_DEC,   1'b0};
        tbl[14] = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b1};
        tbl[15] = '{1'b1, c_XX, 1'b1, S_DEC,   1'b0};
        tbl[16] = '{1'b0, c_RT, 1'b1, S_FETCH, 1'b1};
        tbl[17] = '{1'b1, c_RT, 1'b1, S_IDLE,  1'b0};
        tbl[18] = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b0};
        tbl[19] = '{1'b1, c_AI, 1'b1, S_DEC,   1'b0};
        tbl[20] = '{1'b1, c_XX, 1'b1, S_AEX,   1'b0};
        tbl[21] = '{1'b1, c_XX, 1'b1, S_AWB,   1'b0};
        tbl[22] = '{1'b1, c_RT, 1'b1, S_FETCH, 1'b0};

        do_reset();
        for (int i = 0; i < 23; i++)
            step(tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].ill,
                 $sformatf("tbl[%0d]", i));

        // LW with three stall cycles in MEMRD: 8 cycles from FETCH to MEMWB.
        do_reset();
        step(1'b1, c_RT, 1'b1, S_IDLE,  1'b0, "lw_idle");
        step(1'b1, c_XX, 1'b1, S_FETCH, 1'b0, "lw_fetch");
        step(1'b1, c_LW, 1'b1, S_DEC,   1'b0, "lw_dec");
        step(1'b1, c_LW, 1'b1, S_MADR,  1'b0, "lw_madr");
        for (int i = 0; i < 3; i++)
            step(1'b1, c_RT, 1'b0, S_MRD, 1'b0, "lw_stall");
        step(1'b1, c_RT, 1'b1, S_MRD,   1'b0, "lw_mrd");
        step(1'b1, c_RT, 1'b1, S_MWB,   1'b0, "lw_wb");

        // Reset held two cycles in the middle of MEMRD.
        step(1'b1, c_RT, 1'b1, S_FETCH, 1'b0, "rm_fetch");
        step(1'b1, c_LW, 1'b1, S_DEC,   1'b0, "rm_dec");
        step(1'b1, c_LW, 1'b1, S_MADR,  1'b0, "rm_madr");
        step(1'b0, c_LW, 1'b0, S_MRD,   1'b0, "rm_mrd");
        step(1'b0, c_LW, 1'b1, S_IDLE,  1'b0, "rm_idle0");
        step(1'b1, c_LW, 1'b1, S_IDLE,  1'b0, "rm_idle1");
        step(1'b1, c_RT, 1'b1, S_FETCH, 1'b0, "rm_fetch2");

        // SW with one stall in MEMWR.
        step(1'b1, c_SW, 1'b1, S_DEC,   1'b0, "sw_dec");
        step(1'b1, c_SW, 1'b1, S_MADR,  1'b0, "sw_madr");
        step(1'b1, c_RT, 1'b0, S_MWR,   1'b0, "sw_stall");
        step(1'b1, c_RT, 1'b1, S_MWR,   1'b0, "sw_mwr");

        // Randomized instruction stream; FSM is now entering FETCH.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(6, 0))
                0: op = c_RT;
                1: op = c_LW;
                2: op = c_SW;
                3: op = c_BQ;
                4: op = c_JP;
                5: op = c_AI;
                default: begin
                    op = rop();
                    while (is_legal(op)) op = rop();
                end
            endcase
            push_instr(op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
        prev_ill = 1'b0;
        len = q.size();
        for (int i = 0; i < len; i++) begin
            step(1'b1, q[i].op, q[i].mr, q[i].st, prev_ill, $sformatf("rand[%0d]", i));
            prev_ill = (q[i].st == S_DEC) && !is_legal(q[i].op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
